// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Pipeline stage register with a two-entry main/skid buffer,
//            hold (load-use freeze) and flush (redirect) controls, plus
//            saturating stall and flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // Slot state: main drives the output, skid absorbs one payload when
    // the downstream stalls after in_ready was already promised.
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_occupancy;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;

    // Handshake and next-state wires
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_xfer;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_stall;

    // The skid only fills when main could not drain, so in_ready depends on
    // the skid alone; hold and flush both refuse new payloads.
    assign w_in_ready  = !r_skid_valid && !hold && !flush;
    assign w_out_valid = r_main_valid && !hold;
    assign w_accept    = in_valid && w_in_ready;
    assign w_xfer      = w_out_valid && out_ready;

    // A stall cycle is one where a held main entry does not leave; flush
    // cycles are excluded because the entry is being discarded instead.
    assign w_stall     = r_main_valid && !w_xfer && !flush;

    // Next-state of both slots. Hold needs no explicit branch: it forces
    // accept and xfer low, which leaves every slot unchanged.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_data_nxt  = BUBBLE;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = BUBBLE;
        end else if (!r_main_valid) begin
            // Empty stage: skid is necessarily empty too, so load main.
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                // Drain the skid into main; in_ready was low this cycle.
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
                w_skid_data_nxt  = BUBBLE;
            end else if (w_accept) begin
                // Pass-through: replace the departing entry directly.
                w_main_data_nxt  = in_data;
            end else begin
                w_main_valid_nxt = 1'b0;
                w_main_data_nxt  = BUBBLE;
            end
        end else if (w_accept) begin
            // Main is stuck: park the new payload behind it.
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
        end
    end

    // Register both slots and the occupancy derived from the next valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= BUBBLE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= BUBBLE;
            r_occupancy  <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
        end
    end

    // Saturating performance counters; they stick at all-ones until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = r_main_valid ? r_main_data : BUBBLE;
    assign occupancy    = r_occupancy;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Scoreboard bench for pipe_stage_reg: directed stimulus pushes
//            expected payloads, a monitor pops them on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 4;
    localparam logic [63:0] BUB    = 64'hB0B0_B0B0_B0B0_B0B0;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              hold;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    int                checks = 0;
    int                errors = 0;
    logic [63:0]       exp_q[$];

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (BUB),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .hold         (hold),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake seen on the falling edge must match the head
    // of the expected queue; anything extra is an unexpected payload.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_payload: got 0x%0h expected 0x%0h", out_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        cyc();
        reset = 1'b1;
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",  out_data, BUB);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_stall",     {60'd0, stall_cycles}, 64'd0);
        chk("rst_flushcnt",  {60'd0, flush_count}, 64'd0);
        reset = 1'b1; #1;
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);

        // Streaming
        out_ready = 1'b1;
        push(64'h10); cyc();
        chk("str_occ0",  {62'd0, occupancy}, 64'd1);
        chk("str_data0", out_data, 64'h10);
        push(64'h14); cyc();
        chk("str_occ1",  {62'd0, occupancy}, 64'd1);
        chk("str_data1", out_data, 64'h14);
        push(64'h18); cyc();
        chk("str_occ2",  {62'd0, occupancy}, 64'd1);
        chk("str_data2", out_data, 64'h18);
        in_valid = 1'b0; cyc();
        chk("str_drain_occ",  {62'd0, occupancy}, 64'd0);
        chk("str_drain_data", out_data, BUB);
        chk("str_stall",      {60'd0, stall_cycles}, 64'd0);

        // Backpressure
        do_reset();
        push(64'h10); cyc();
        push(64'h14); cyc();
        chk("bp_occ2", {62'd0, occupancy}, 64'd2);
        in_valid = 1'b1; in_data = 64'h99; #1;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        chk("bp_occ_after_refused", {62'd0, occupancy}, 64'd2);
        chk("bp_main_data", out_data, 64'h10);
        in_valid = 1'b0; out_ready = 1'b1; cyc();
        chk("bp_occ1",  {62'd0, occupancy}, 64'd1);
        chk("bp_data1", out_data, 64'h14);
        chk("bp_stall", {60'd0, stall_cycles}, 64'd2);
        cyc();
        chk("bp_occ0",   {62'd0, occupancy}, 64'd0);
        chk("bp_bubble", out_data, BUB);

        // Hold
        do_reset();
        push(64'h20); cyc();
        in_valid = 1'b1; in_data = 64'h77; hold = 1'b1; out_ready = 1'b1; #1;
        chk("hold_out_valid", {63'd0, out_valid}, 64'd0);
        chk("hold_in_ready",  {63'd0, in_ready}, 64'd0);
        cyc(); cyc(); cyc();
        chk("hold_data",  out_data, 64'h20);
        chk("hold_occ",   {62'd0, occupancy}, 64'd1);
        chk("hold_stall", {60'd0, stall_cycles}, 64'd3);
        hold = 1'b0; in_valid = 1'b0; cyc();
        chk("hold_rel_occ",   {62'd0, occupancy}, 64'd0);
        chk("hold_rel_stall", {60'd0, stall_cycles}, 64'd3);
        cyc();

        // Flush with two entries held and a payload offered
        do_reset();
        push(64'h24); cyc();
        push(64'h28); cyc();
        chk("fl_occ2", {62'd0, occupancy}, 64'd2);
        exp_q.delete();
        flush = 1'b1; in_valid = 1'b1; in_data = 64'h30; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ0",  {62'd0, occupancy}, 64'd0);
        chk("fl_data",  out_data, BUB);
        chk("fl_count", {60'd0, flush_count}, 64'd1);
        out_ready = 1'b1; cyc(); cyc(); cyc();

        // Flush and hold together: flush wins
        out_ready = 1'b0;
        push(64'h40); cyc();
        in_valid = 1'b0;
        chk("fh_occ1", {62'd0, occupancy}, 64'd1);
        exp_q.delete();
        flush = 1'b1; hold = 1'b1; cyc();
        flush = 1'b0; hold = 1'b0;
        chk("fh_occ0",  {62'd0, occupancy}, 64'd0);
        chk("fh_count", {60'd0, flush_count}, 64'd2);
        out_ready = 1'b1; cyc(); cyc();

        // Stall counter saturation, then reset clears everything
        out_ready = 1'b0;
        push(64'h50); cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall", {60'd0, stall_cycles}, 64'd15);
        do_reset();
        chk("sat_rst_stall", {60'd0, stall_cycles}, 64'd0);
        chk("sat_rst_flush", {60'd0, flush_count}, 64'd0);
        chk("sat_rst_occ",   {62'd0, occupancy}, 64'd0);
        out_ready = 1'b1; cyc(); cyc(); cyc();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
